// File: rtl/ysyx_22041412_sram_pkg.sv
// Shared types and helpers for the SRAM bank: FSM states, legal read
// latencies and the byte-merge used by both the write path and forwarding.
package ysyx_22041412_sram_pkg;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W = 1024;
    localparam int MERGE_B = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] merge_bytes(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_B-1:0] strb
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_B; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22041412_sram_bank_if.sv
// Read/write request bus of the SRAM bank.
// master drives rd_valid/rd_addr and wr_*; slave returns readies and rd_data/rd_data_valid/rd_err.
interface ysyx_22041412_sram_bank_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
);

    logic                    rd_valid;
    logic                    rd_ready;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_data_valid;
    logic                    rd_err;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;

    modport master (
        output rd_valid, rd_addr,
        output wr_valid, wr_addr, wr_data, wr_strb,
        input  rd_ready, rd_data, rd_data_valid, rd_err,
        input  wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr,
        input  wr_valid, wr_addr, wr_data, wr_strb,
        output rd_ready, rd_data, rd_data_valid, rd_err,
        output wr_ready
    );

endinterface

// File: rtl/ysyx_22041412_sram_clr.sv
// Post-reset clear sequencer: walks clr_addr 0..DATA_DEPTH-1 with clr_we high,
// then raises init_done. Ports: clk, rst_n, clr_we, clr_addr, init_done.
module ysyx_22041412_sram_clr
    import ysyx_22041412_sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_DEPTH     = 4096,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic SWEEP = (CLEAR_ON_RESET != 0);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            clr_we    <= SWEEP;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    if (!SWEEP || clr_cnt == LAST) begin
                        state     <= S_RUN;
                        clr_we    <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    assign clr_addr = clr_cnt;

endmodule

// File: rtl/ysyx_22041412_sram_bank.sv
// Single SRAM bank with independent strobed write and pipelined read ports.
// Ports: clk, rst_n, bus (slave side of the request interface), init_done.
module ysyx_22041412_sram_bank
    import ysyx_22041412_sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int DATA_DEPTH     = 4096,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_22041412_sram_bank_if.slave bus,
    output logic init_done
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ysyx_22041412_sram_clr #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_DEPTH     (DATA_DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign bus.rd_ready = init_done;
    assign bus.wr_ready = init_done;

    logic rd_acc;
    logic wr_acc;
    logic rd_in;
    logic wr_in;
    logic wr_go;
    logic coll;

    assign rd_acc = bus.rd_valid & init_done;
    assign wr_acc = bus.wr_valid & init_done;
    assign rd_in  = {1'b0, bus.rd_addr} < DEPTH_X;
    assign wr_in  = {1'b0, bus.wr_addr} < DEPTH_X;
    assign wr_go  = wr_acc & wr_in;
    assign coll   = wr_go & (bus.wr_addr == bus.rd_addr);

    // Clear sweep and user writes share one array port; they never overlap
    // because user writes need init_done.
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;

    always_comb begin
        we    = clr_we | wr_go;
        waddr = bus.wr_addr;
        wdata = bus.wr_data;
        wstrb = bus.wr_strb;
        if (clr_we) begin
            waddr = clr_addr;
            wdata = '0;
            wstrb = '1;
        end
    end

    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] fwd_word;

    assign wr_word = DATA_WIDTH'(merge_bytes(MERGE_W'(mem[waddr]),
                                             MERGE_W'(wdata),
                                             MERGE_B'(wstrb)));

    // Write-first: a same-edge write to the read address is folded in.
    assign rd_word  = mem[bus.rd_addr];
    assign fwd_word = coll
        ? DATA_WIDTH'(merge_bytes(MERGE_W'(rd_word),
                                  MERGE_W'(bus.wr_data),
                                  MERGE_B'(bus.wr_strb)))
        : rd_word;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wr_word;
        end
    end

    // s0 snapshots the word at the accept edge, so later writes cannot
    // touch an in-flight read.
    logic                  s0_valid;
    logic                  s0_err;
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s1_valid;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_err   <= 1'b0;
            s0_data  <= '0;
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s0_valid <= rd_acc;
            s0_err   <= rd_acc & ~rd_in;
            if (rd_acc) begin
                s0_data <= rd_in ? fwd_word : '0;
            end
            s1_valid <= s0_valid;
            s1_err   <= s0_err;
            if (s0_valid) begin
                s1_data <= s0_data;
            end
        end
    end

    if (RD_LATENCY == RD_LAT_2) begin : g_lat2
        logic                  s2_valid;
        logic                  s2_err;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign bus.rd_data       = s2_data;
        assign bus.rd_data_valid = s2_valid;
        assign bus.rd_err        = s2_err;
    end else begin : g_lat1
        assign bus.rd_data       = s1_data;
        assign bus.rd_data_valid = s1_valid;
        assign bus.rd_err        = s1_err;
    end

endmodule

// File: tb/tb_ysyx_22041412_sram_bank.sv
// Bench for ysyx_22041412_sram_bank: bank A (defaults, latency 1) and
// bank B (3000 words, latency 2) receive identical requests.
module tb_ysyx_22041412_sram_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_a;
    logic init_b;

    always #5 clk = ~clk;

    ysyx_22041412_sram_bank_if #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) ifa ();
    ysyx_22041412_sram_bank_if #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) ifb ();

    ysyx_22041412_sram_bank #(
        .ADDR_WIDTH(12), .DATA_WIDTH(64), .DATA_DEPTH(4096),
        .RD_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .init_done(init_a)
    );

    ysyx_22041412_sram_bank #(
        .ADDR_WIDTH(12), .DATA_WIDTH(64), .DATA_DEPTH(3000),
        .RD_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .init_done(init_b)
    );

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          t;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        xa;
    exp_t        xb;
    logic [63:0] ma [4096];
    logic [63:0] mb [3000];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          pulses_a = 0;
    int          pulses_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mrg(input logic [63:0] o,
                                        input logic [63:0] n,
                                        input logic [7:0]  s);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++)
            if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (ifa.rd_data_valid === 1'b1) begin
            pulses_a++;
            checks++;
            if (qa.size() == 0) begin
                $display("FAIL rd_a_unexpected data=%h err=%b cyc=%0d",
                         ifa.rd_data, ifa.rd_err, cyc);
            end else begin
                xa = qa.pop_front();
                if (ifa.rd_data !== xa.d || ifa.rd_err !== xa.e || cyc != xa.t)
                    $display("FAIL rd_a got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                             ifa.rd_data, ifa.rd_err, cyc, xa.d, xa.e, xa.t);
                else
                    passed++;
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.rd_data_valid === 1'b1) begin
            pulses_b++;
            checks++;
            if (qb.size() == 0) begin
                $display("FAIL rd_b_unexpected data=%h err=%b cyc=%0d",
                         ifb.rd_data, ifb.rd_err, cyc);
            end else begin
                xb = qb.pop_front();
                if (ifb.rd_data !== xb.d || ifb.rd_err !== xb.e || cyc != xb.t)
                    $display("FAIL rd_b got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                             ifb.rd_data, ifb.rd_err, cyc, xb.d, xb.e, xb.t);
                else
                    passed++;
            end
        end
    end

    task automatic drive(input bit rv, input logic [11:0] ra,
                         input bit wv, input logic [11:0] wa,
                         input logic [63:0] wd, input logic [7:0] ws);
        exp_t x;
        @(negedge clk);
        ifa.rd_valid = rv;  ifb.rd_valid = rv;
        ifa.rd_addr  = ra;  ifb.rd_addr  = ra;
        ifa.wr_valid = wv;  ifb.wr_valid = wv;
        ifa.wr_addr  = wa;  ifb.wr_addr  = wa;
        ifa.wr_data  = wd;  ifb.wr_data  = wd;
        ifa.wr_strb  = ws;  ifb.wr_strb  = ws;
        if (wv && ifa.wr_ready === 1'b1) ma[wa] = mrg(ma[wa], wd, ws);
        if (wv && ifb.wr_ready === 1'b1 && wa < 12'd3000) mb[wa] = mrg(mb[wa], wd, ws);
        if (rv && ifa.rd_ready === 1'b1) begin
            x.d = ma[ra];
            x.e = 1'b0;
            x.t = cyc + 2;
            qa.push_back(x);
        end
        if (rv && ifb.rd_ready === 1'b1) begin
            x.d = (ra < 12'd3000) ? mb[ra] : 64'h0;
            x.e = (ra >= 12'd3000);
            x.t = cyc + 3;
            qb.push_back(x);
        end
    endtask

    task automatic idle();
        drive(1'b0, 12'h0, 1'b0, 12'h0, 64'h0, 8'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (qa.size() != 0 || qb.size() != 0); i++)
            @(posedge clk);
        @(posedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL drain pending_a=%0d pending_b=%0d want 0/0",
                     qa.size(), qb.size());
        else
            passed++;
    endtask

    task automatic zero_models();
        foreach (ma[i]) ma[i] = 64'h0;
        foreach (mb[i]) mb[i] = 64'h0;
    endtask

    // Counts edges after rst_n rises until each bank reports init_done;
    // each bank's rd_valid is dropped as soon as it becomes ready.
    task automatic wait_init(output int fa, output int fb, output bit bad);
        fa = 0;
        fb = 0;
        bad = 1'b0;
        for (int k = 1; k <= 4110; k++) begin
            @(posedge clk);
            #1;
            if (ifa.rd_ready !== init_a || ifa.wr_ready !== init_a) bad = 1'b1;
            if (ifb.rd_ready !== init_b || ifb.wr_ready !== init_b) bad = 1'b1;
            if (fa == 0 && init_a === 1'b1) begin
                fa = k;
                ifa.rd_valid = 1'b0;
            end
            if (fb == 0 && init_b === 1'b1) begin
                fb = k;
                ifb.rd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        int  fa;
        int  fb;
        bit  bad;
        rst_n = 1'b0;
        ifa.wr_valid = 1'b0; ifb.wr_valid = 1'b0;
        ifa.wr_addr = '0;    ifb.wr_addr = '0;
        ifa.wr_data = '0;    ifb.wr_data = '0;
        ifa.wr_strb = '0;    ifb.wr_strb = '0;
        ifa.rd_valid = 1'b1; ifb.rd_valid = 1'b1;
        ifa.rd_addr = 12'h7FF; ifb.rd_addr = 12'h7FF;
        zero_models();
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.rd_data, ifa.rd_data_valid, ifa.rd_err, ifa.rd_ready,
             ifa.wr_ready, init_a} !== 69'h0)
            $display("FAIL reset_a data=%h v=%b e=%b rr=%b wr=%b id=%b want all 0",
                     ifa.rd_data, ifa.rd_data_valid, ifa.rd_err,
                     ifa.rd_ready, ifa.wr_ready, init_a);
        else
            passed++;
        checks++;
        if ({ifb.rd_data, ifb.rd_data_valid, ifb.rd_err, ifb.rd_ready,
             ifb.wr_ready, init_b} !== 69'h0)
            $display("FAIL reset_b data=%h v=%b e=%b rr=%b wr=%b id=%b want all 0",
                     ifb.rd_data, ifb.rd_data_valid, ifb.rd_err,
                     ifb.rd_ready, ifb.wr_ready, init_b);
        else
            passed++;
        rst_n = 1'b1;
        wait_init(fa, fb, bad);
        checks++;
        if (fa != 4096) $display("FAIL clear_len_a got=%0d want=4096", fa);
        else passed++;
        checks++;
        if (fb != 3000) $display("FAIL clear_len_b got=%0d want=3000", fb);
        else passed++;
        checks++;
        if (bad) $display("FAIL ready_vs_init got=mismatch want=ready==init_done");
        else passed++;
        drive(1'b1, 12'h7FF, 1'b0, 12'h0, 64'h0, 8'h0);
        idle();
        drain();
    endtask

    task automatic test_strobed_write();
        drive(1'b0, 12'h0, 1'b1, 12'd5, 64'h1122334455667788, 8'hFF);
        drive(1'b0, 12'h0, 1'b1, 12'd5, 64'h000000000000AABB, 8'h03);
        drive(1'b1, 12'd5, 1'b0, 12'h0, 64'h0, 8'h0);
        idle();
        drain();
        checks++;
        if (ifa.rd_data !== 64'h112233445566AABB)
            $display("FAIL strobe_a got=%h want=112233445566aabb", ifa.rd_data);
        else
            passed++;
        checks++;
        if (ifb.rd_data !== 64'h112233445566AABB)
            $display("FAIL strobe_b got=%h want=112233445566aabb", ifb.rd_data);
        else
            passed++;
    endtask

    task automatic test_collision();
        drive(1'b1, 12'd9, 1'b1, 12'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        drive(1'b0, 12'h0, 1'b1, 12'd9, 64'h0000_0000_0000_1234, 8'hFF);
        idle();
        drain();
        checks++;
        if (ifa.rd_data !== 64'h00000000FFFFFFFF)
            $display("FAIL collide_a got=%h want=00000000ffffffff", ifa.rd_data);
        else
            passed++;
        checks++;
        if (ifb.rd_data !== 64'h00000000FFFFFFFF)
            $display("FAIL collide_b got=%h want=00000000ffffffff", ifb.rd_data);
        else
            passed++;
        drive(1'b1, 12'd9, 1'b0, 12'h0, 64'h0, 8'h0);
        idle();
        drain();
        checks++;
        if (ifb.rd_data !== 64'h0000000000001234)
            $display("FAIL collide_after_b got=%h want=1234", ifb.rd_data);
        else
            passed++;
    endtask

    task automatic test_range();
        drive(1'b0, 12'h0, 1'b1, 12'd3500, 64'h00000000DEADBEEF, 8'hFF);
        drive(1'b1, 12'd3500, 1'b0, 12'h0, 64'h0, 8'h0);
        idle();
        drain();
        checks++;
        if (ifb.rd_data !== 64'h0)
            $display("FAIL range_b got=%h want=0", ifb.rd_data);
        else
            passed++;
        checks++;
        if (ifa.rd_data !== 64'h00000000DEADBEEF)
            $display("FAIL range_a got=%h want=deadbeef", ifa.rd_data);
        else
            passed++;
        drive(1'b1, 12'd500, 1'b0, 12'h0, 64'h0, 8'h0);
        drive(1'b1, 12'd1452, 1'b0, 12'h0, 64'h0, 8'h0);
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        int p0a;
        int p0b;
        p0a = pulses_a;
        p0b = pulses_b;
        for (int i = 0; i < 256; i++)
            drive(1'b1, 12'(i), 1'b1, 12'(255 - i),
                  {$urandom, $urandom}, 8'($urandom));
        idle();
        drain();
        checks++;
        if (pulses_a - p0a != 256)
            $display("FAIL stream_a pulses got=%0d want=256", pulses_a - p0a);
        else
            passed++;
        checks++;
        if (pulses_b - p0b != 256)
            $display("FAIL stream_b pulses got=%0d want=256", pulses_b - p0b);
        else
            passed++;
    endtask

    task automatic test_mid_reset();
        int fa;
        int fb;
        bit bad;
        drive(1'b1, 12'd5, 1'b0, 12'h0, 64'h0, 8'h0);
        drive(1'b1, 12'd6, 1'b0, 12'h0, 64'h0, 8'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ifa.rd_valid = 1'b0; ifb.rd_valid = 1'b0;
        qa.delete();
        qb.delete();
        zero_models();
        #1;
        checks++;
        if ({ifa.rd_data, ifa.rd_data_valid, ifa.rd_err, ifa.rd_ready,
             init_a} !== 68'h0)
            $display("FAIL midrst_a data=%h v=%b e=%b rr=%b id=%b want all 0",
                     ifa.rd_data, ifa.rd_data_valid, ifa.rd_err,
                     ifa.rd_ready, init_a);
        else
            passed++;
        checks++;
        if ({ifb.rd_data, ifb.rd_data_valid, ifb.rd_err, ifb.rd_ready,
             init_b} !== 68'h0)
            $display("FAIL midrst_b data=%h v=%b e=%b rr=%b id=%b want all 0",
                     ifb.rd_data, ifb.rd_data_valid, ifb.rd_err,
                     ifb.rd_ready, init_b);
        else
            passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init(fa, fb, bad);
        checks++;
        if (fa != 4096 || fb != 3000)
            $display("FAIL reclear_len got=%0d/%0d want=4096/3000", fa, fb);
        else
            passed++;
        checks++;
        if (bad) $display("FAIL reclear_ready got=mismatch want=ready==init_done");
        else passed++;
        drive(1'b1, 12'd5, 1'b0, 12'h0, 64'h0, 8'h0);
        idle();
        drain();
        checks++;
        if (ifa.rd_data !== 64'h0 || ifb.rd_data !== 64'h0)
            $display("FAIL reclear_data got=%h/%h want=0/0", ifa.rd_data, ifb.rd_data);
        else
            passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_strobed_write();
        test_collision();
        test_range();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
